// File: rtl/io_fifo_pkg.sv
// io_fifo_pkg: register offsets and STATUS bit positions shared by the
// io_fifo_bridge peripheral and anything that decodes its register window.
package io_fifo_pkg;

    localparam logic [7:0] IOF_STATUS  = 8'h00;
    localparam logic [7:0] IOF_RXDATA  = 8'h04;
    localparam logic [7:0] IOF_TXDATA  = 8'h08;
    localparam logic [7:0] IOF_RXCOUNT = 8'h0C;
    localparam logic [7:0] IOF_TXCOUNT = 8'h10;
    localparam logic [7:0] IOF_CLEAR   = 8'h14;
    localparam logic [7:0] IOF_IRQEN   = 8'h18;

    localparam int ST_TX_NOT_FULL  = 0;
    localparam int ST_RX_NOT_EMPTY = 1;
    localparam int ST_RX_OVERFLOW  = 2;
    localparam int ST_TX_DROP      = 3;

    localparam int CLR_RX_OVERFLOW = 0;
    localparam int CLR_TX_DROP     = 1;

endpackage

// File: rtl/io_fifo_bridge_sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head output.
// A pop on an empty FIFO is ignored; a push on a full FIFO only lands when a
// pop happens in the same cycle, so a full FIFO can stream at full rate.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_fifo_bridge.sv
// io_fifo_bridge: memory-mapped UART buffering peripheral with an RX FIFO
// (receiver -> CPU) and a TX FIFO (CPU -> transmitter).
// Optional macro IO_FIFO_IRQ_EN adds the IRQEN register at 0x18 and a
// registered irq output.
module io_fifo_bridge
    import io_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [7:0]  rx_in_data,
    input  logic        rx_in_valid,
    output logic        rx_in_ready,
    output logic [7:0]  tx_out_data,
    output logic        tx_out_valid,
    input  logic        tx_out_ready
`ifdef IO_FIFO_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic          rx_full;
    logic          rx_empty;
    logic [CW-1:0] rx_count;
    logic [7:0]    rx_head;
    logic          tx_full;
    logic          tx_empty;
    logic [CW-1:0] tx_count;

    logic          rx_rd;
    logic          rx_push;
    logic          tx_wr;
    logic          tx_pop;
    logic          clr_wr;
    logic          rx_overflow;
    logic          tx_drop;
    logic          overflow_set;
    logic          drop_set;
    logic [3:0]    status;
    logic [31:0]   rd_data;
    logic          unused_din;

    assign unused_din = ^din[31:8];

    assign rx_rd  = en && !we && (addr == IOF_RXDATA);
    assign tx_wr  = en &&  we && (addr == IOF_TXDATA);
    assign clr_wr = en &&  we && (addr == IOF_CLEAR);

    // A CPU pop of a full RX FIFO frees the slot in the same cycle, so the
    // receiver may hand over a byte then and it lands at the tail.
    assign rx_in_ready  = !rst && (!rx_full || rx_rd);
    assign rx_push      = rx_in_valid && rx_in_ready;
    assign overflow_set = rx_in_valid && !rx_in_ready;

    assign tx_out_valid = !tx_empty;
    assign tx_pop       = tx_out_valid && tx_out_ready;
    assign drop_set     = tx_wr && tx_full && !tx_pop;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_rd),
        .din   (rx_in_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_wr),
        .pop   (tx_pop),
        .din   (din[7:0]),
        .dout  (tx_out_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_overflow <= 1'b0;
            tx_drop     <= 1'b0;
        end else begin
            rx_overflow <= overflow_set || (rx_overflow && !(clr_wr && din[CLR_RX_OVERFLOW]));
            tx_drop     <= drop_set     || (tx_drop     && !(clr_wr && din[CLR_TX_DROP]));
        end
    end

`ifdef IO_FIFO_IRQ_EN
    logic [1:0] irqen;

    // Interrupt enable register and registered interrupt request.
    always_ff @(posedge clk) begin
        if (rst) begin
            irqen <= 2'b00;
            irq   <= 1'b0;
        end else begin
            if (en && we && (addr == IOF_IRQEN)) begin
                irqen <= din[1:0];
            end
            irq <= |(irqen & {!tx_full, !rx_empty});
        end
    end
`endif

    // Read mux: value seen by the CPU reflects state before the access edge.
    always_comb begin
        status                  = 4'b0000;
        status[ST_TX_NOT_FULL]  = !tx_full;
        status[ST_RX_NOT_EMPTY] = !rx_empty;
        status[ST_RX_OVERFLOW]  = rx_overflow;
        status[ST_TX_DROP]      = tx_drop;
        rd_data                 = 32'h0;
        case (addr)
            IOF_STATUS:  rd_data = {28'h0, status};
            IOF_RXDATA:  rd_data = rx_empty ? 32'h0 : {24'h0, rx_head};
            IOF_RXCOUNT: rd_data = {{(32-CW){1'b0}}, rx_count};
            IOF_TXCOUNT: rd_data = {{(32-CW){1'b0}}, tx_count};
`ifdef IO_FIFO_IRQ_EN
            IOF_IRQEN:   rd_data = {30'h0, irqen};
`endif
            default:     rd_data = 32'h0;
        endcase
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= 32'h0;
        end else if (en && !we) begin
            dout <= rd_data;
        end
    end

endmodule

// File: tb/tb_io_fifo_bridge.sv
// tb_io_fifo_bridge: directed self-checking bench for io_fifo_bridge (DEPTH=8).
// Build with IO_FIFO_IRQ_EN defined to also exercise the irq output.
module tb_io_fifo_bridge;

    logic        clk;
    logic        rst;
    logic        en;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [7:0]  rx_in_data;
    logic        rx_in_valid;
    logic        rx_in_ready;
    logic [7:0]  tx_out_data;
    logic        tx_out_valid;
    logic        tx_out_ready;
`ifdef IO_FIFO_IRQ_EN
    logic        irq;
`endif

    int checks;
    int failures;
    logic [31:0] rd;

    io_fifo_bridge #(.DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .we           (we),
        .addr         (addr),
        .din          (din),
        .dout         (dout),
        .rx_in_data   (rx_in_data),
        .rx_in_valid  (rx_in_valid),
        .rx_in_ready  (rx_in_ready),
        .tx_out_data  (tx_out_data),
        .tx_out_valid (tx_out_valid),
        .tx_out_ready (tx_out_ready)
`ifdef IO_FIFO_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle; outputs are sampled 1 ns after the edge.
    task automatic applyStimulus(input logic e, input logic w, input logic [7:0] a, input logic [31:0] d);
        en   = e;
        we   = w;
        addr = a;
        din  = d;
        tick();
        en   = 1'b0;
        we   = 1'b0;
        din  = 32'h0;
    endtask

    task automatic busRead(input logic [7:0] a, output logic [31:0] d);
        applyStimulus(1'b1, 1'b0, a, 32'h0);
        d = dout;
    endtask

    task automatic busWrite(input logic [7:0] a, input logic [31:0] d);
        applyStimulus(1'b1, 1'b1, a, d);
    endtask

    task automatic rxOffer(input logic [7:0] b);
        rx_in_valid = 1'b1;
        rx_in_data  = b;
        tick();
        rx_in_valid = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        en           = 1'b0;
        we           = 1'b0;
        addr         = 8'h00;
        din          = 32'h0;
        rx_in_data   = 8'h00;
        rx_in_valid  = 1'b0;
        tx_out_ready = 1'b0;

        tick();
        tick();
        checkOutput("reset_dout", dout, 32'h0);
        checkOutput("reset_rx_ready", {31'h0, rx_in_ready}, 32'h0);
        checkOutput("reset_tx_valid", {31'h0, tx_out_valid}, 32'h0);
        rst = 1'b0;
        tick();

        busRead(8'h00, rd);
        checkOutput("status_after_reset", rd, 32'h1);
        checkOutput("rx_ready_idle", {31'h0, rx_in_ready}, 32'h1);
        checkOutput("tx_valid_idle", {31'h0, tx_out_valid}, 32'h0);

        // RX path: two bytes in, read count and data, then empty read.
        rxOffer(8'hA5);
        rxOffer(8'h3C);
        busRead(8'h0C, rd);
        checkOutput("rxcount_2", rd, 32'h2);
        busRead(8'h04, rd);
        checkOutput("rxdata_first", rd, 32'hA5);
        busRead(8'h04, rd);
        checkOutput("rxdata_second", rd, 32'h3C);
        busRead(8'h04, rd);
        checkOutput("rxdata_empty", rd, 32'h0);
        busRead(8'h00, rd);
        checkOutput("status_rx_empty", rd, 32'h1);

        // TX path: overfill with the transmitter stalled, then drain.
        for (int i = 0; i < 9; i++) begin
            busWrite(8'h08, 32'h10 + i);
        end
        busRead(8'h10, rd);
        checkOutput("txcount_full", rd, 32'h8);
        busRead(8'h00, rd);
        checkOutput("status_tx_drop", rd, 32'h8);
        checkOutput("tx_valid_full", {31'h0, tx_out_valid}, 32'h1);
        tx_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("tx_byte_%0d", i), {24'h0, tx_out_data}, 32'h10 + i);
            tick();
        end
        tx_out_ready = 1'b0;
        checkOutput("tx_valid_drained", {31'h0, tx_out_valid}, 32'h0);
        busWrite(8'h14, 32'h2);
        busRead(8'h00, rd);
        checkOutput("status_drop_cleared", rd, 32'h1);

        // RX overflow: fill, offer one more, then clear the flag.
        for (int i = 0; i < 8; i++) begin
            rxOffer(8'h40 + 8'(i));
        end
        checkOutput("rx_ready_full", {31'h0, rx_in_ready}, 32'h0);
        rxOffer(8'h99);
        busRead(8'h0C, rd);
        checkOutput("rxcount_full", rd, 32'h8);
        busRead(8'h00, rd);
        checkOutput("status_overflow", rd, 32'h7);
        busWrite(8'h14, 32'h1);
        busRead(8'h00, rd);
        checkOutput("status_ovf_cleared", rd, 32'h3);

        // Full RX FIFO: receiver handshake and CPU pop in the same cycle.
        rx_in_valid = 1'b1;
        rx_in_data  = 8'h77;
        en          = 1'b1;
        we          = 1'b0;
        addr        = 8'h04;
        #1;
        checkOutput("rx_ready_full_pop", {31'h0, rx_in_ready}, 32'h1);
        @(posedge clk);
        #1;
        rx_in_valid = 1'b0;
        en          = 1'b0;
        checkOutput("simul_old_head", dout, 32'h40);
        busRead(8'h0C, rd);
        checkOutput("simul_count", rd, 32'h8);
        for (int i = 1; i < 8; i++) begin
            busRead(8'h04, rd);
            checkOutput($sformatf("drain_%0d", i), rd, 32'h40 + i);
        end
        busRead(8'h04, rd);
        checkOutput("drain_tail_new", rd, 32'h77);
        busRead(8'h00, rd);
        checkOutput("status_no_ovf", rd, 32'h1);

        // Unmapped read and write to a read-only offset.
        busRead(8'h1C, rd);
        checkOutput("unmapped_read", rd, 32'h0);
        busWrite(8'h04, 32'hFF);
        busRead(8'h0C, rd);
        checkOutput("ro_write_ignored", rd, 32'h0);

        // Reset mid-operation discards contents and the in-flight byte.
        rxOffer(8'h11);
        busWrite(8'h08, 32'h22);
        busRead(8'h0C, rd);
        checkOutput("pre_reset_rxcount", rd, 32'h1);
        rst         = 1'b1;
        rx_in_valid = 1'b1;
        rx_in_data  = 8'h33;
        tick();
        rx_in_valid = 1'b0;
        rst         = 1'b0;
        checkOutput("midreset_dout", dout, 32'h0);
        checkOutput("midreset_tx_valid", {31'h0, tx_out_valid}, 32'h0);
        busRead(8'h0C, rd);
        checkOutput("midreset_rxcount", rd, 32'h0);
        busRead(8'h10, rd);
        checkOutput("midreset_txcount", rd, 32'h0);

`ifdef IO_FIFO_IRQ_EN
        // Interrupt on RX not empty, deasserting after the byte is read.
        busWrite(8'h18, 32'h1);
        busRead(8'h18, rd);
        checkOutput("irqen_readback", rd, 32'h1);
        checkOutput("irq_idle", {31'h0, irq}, 32'h0);
        rxOffer(8'h55);
        tick();
        checkOutput("irq_set", {31'h0, irq}, 32'h1);
        busRead(8'h04, rd);
        checkOutput("irq_rxdata", rd, 32'h55);
        tick();
        checkOutput("irq_cleared", {31'h0, irq}, 32'h0);
`else
        busWrite(8'h18, 32'h3);
        busRead(8'h18, rd);
        checkOutput("irqen_absent", rd, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
